// File: rtl/ms7200_vin_align.sv
// Pixel-domain video alignment stage after the MS7200 control block: measures active geometry,
// locks after LOCK_FRAMES identical frames and gates the stream frame-aligned. Option: VIN_ALIGN_STAT_EN.
module ms7200_vin_align #(
    parameter int          DATA_W      = 24,
    parameter logic        VS_POL      = 1'b1,
    parameter logic        HS_POL      = 1'b1,
    parameter int          LOCK_FRAMES = 3,
    parameter logic [23:0] TIMEOUT     = 24'd4_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_over,
    input  logic              vin_vs,
    input  logic              vin_hs,
    input  logic              vin_de,
    input  logic [DATA_W-1:0] vin_data,
    output logic              vout_vs,
    output logic              vout_hs,
    output logic              vout_de,
    output logic [DATA_W-1:0] vout_data,
    output logic              video_locked,
    output logic              lock_lost,
    output logic [11:0]       h_active,
    output logic [11:0]       v_active,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {WAIT_CFG, SYNC, MEASURE, LOCKED} state_t;

    localparam logic [11:0] CNT_MAX = 12'hFFF;

    state_t            state_q, state_d;
    logic              initMeta_q, initSync_q;
    logic              vs_q, de_q;
    logic [11:0]       pixCnt_q, pixCnt_d;
    logic [11:0]       lineCnt_q, lineCnt_d;
    logic [11:0]       lineLen_q, lineLen_d;
    logic              bad_q, bad_d;
    logic              skip_q, skip_d;
    logic [11:0]       refH_q, refH_d, refV_q, refV_d;
    logic [15:0]       stable_q, stable_d;
    logic [23:0]       toCnt_q, toCnt_d;
    logic [11:0]       hAct_q, hAct_d, vAct_q, vAct_d;
    logic              locked_q, lockLost_q;
    logic              voutVs_q, voutHs_q, voutDe_q;
    logic [DATA_W-1:0] voutData_q;
    logic              fs, lineEnd, frameValid, sameRef, toHit, pass, loss;

    // vs_q resets to the active level so a VS already active at reset release is not taken as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            initMeta_q <= 1'b0;
            initSync_q <= 1'b0;
            vs_q       <= VS_POL;
            de_q       <= 1'b0;
        end else begin
            initMeta_q <= init_over;
            initSync_q <= initMeta_q;
            vs_q       <= vin_vs;
            de_q       <= vin_de;
        end
    end

    assign fs      = (vin_vs == VS_POL) && (vs_q != VS_POL);
    assign lineEnd = de_q && !vin_de;

    // A line still open at fs is flagged by skip and dropped when it ends
    always_comb begin
        pixCnt_d  = pixCnt_q;
        lineCnt_d = lineCnt_q;
        lineLen_d = lineLen_q;
        bad_d     = bad_q;
        skip_d    = skip_q;
        if (fs) begin
            pixCnt_d  = '0;
            lineCnt_d = '0;
            lineLen_d = '0;
            bad_d     = 1'b0;
            skip_d    = vin_de;
        end else if (vin_de) begin
            if (pixCnt_q == CNT_MAX) bad_d = bad_q | ~skip_q;
            else                     pixCnt_d = pixCnt_q + 12'd1;
        end else if (lineEnd) begin
            pixCnt_d = '0;
            skip_d   = 1'b0;
            if (!skip_q) begin
                if (lineCnt_q == '0)            lineLen_d = pixCnt_q;
                else if (pixCnt_q != lineLen_q) bad_d = 1'b1;
                if (lineCnt_q == CNT_MAX) bad_d = 1'b1;
                else                      lineCnt_d = lineCnt_q + 12'd1;
            end
        end
    end

    assign frameValid = !bad_q && (lineLen_q != '0) && (lineCnt_q != '0);
    assign sameRef    = (lineLen_q == refH_q) && (lineCnt_q == refV_q);
    assign toHit      = (toCnt_q == TIMEOUT) && !fs;
    assign toCnt_d    = fs ? '0 : ((toCnt_q == TIMEOUT) ? toCnt_q : toCnt_q + 24'd1);

    always_comb begin
        state_d  = state_q;
        refH_d   = refH_q;
        refV_d   = refV_q;
        stable_d = stable_q;
        hAct_d   = hAct_q;
        vAct_d   = vAct_q;
        pass     = 1'b0;
        loss     = 1'b0;
        case (state_q)
            WAIT_CFG: begin
                if (initSync_q) state_d = SYNC;
            end
            SYNC: begin
                if (fs) begin
                    state_d  = MEASURE;
                    stable_d = '0;
                end
            end
            MEASURE: begin
                if (fs) begin
                    if (!frameValid) begin
                        stable_d = '0;
                    end else if (sameRef) begin
                        if (stable_q != '1) stable_d = stable_q + 16'd1;
                    end else begin
                        refH_d   = lineLen_q;
                        refV_d   = lineCnt_q;
                        stable_d = 16'd1;
                    end
                    if (frameValid && (stable_d >= 16'(LOCK_FRAMES))) begin
                        state_d = LOCKED;
                        hAct_d  = lineLen_q;
                        vAct_d  = lineCnt_q;
                        pass    = 1'b1;
                    end
                end else if (toHit) begin
                    state_d = SYNC;
                end
            end
            LOCKED: begin
                if (fs) begin
                    if (!frameValid || !sameRef) begin
                        loss    = 1'b1;
                        state_d = MEASURE;
                        if (frameValid) begin
                            refH_d   = lineLen_q;
                            refV_d   = lineCnt_q;
                            stable_d = 16'd1;
                        end else begin
                            stable_d = '0;
                        end
                    end else begin
                        pass = 1'b1;
                    end
                end else if (toHit) begin
                    loss    = 1'b1;
                    state_d = SYNC;
                end else begin
                    pass = 1'b1;
                end
            end
            default: state_d = WAIT_CFG;
        endcase
        if (!initSync_q) begin
            state_d = WAIT_CFG;
            pass    = 1'b0;
            loss    = (state_q == LOCKED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_CFG;
            pixCnt_q   <= '0;
            lineCnt_q  <= '0;
            lineLen_q  <= '0;
            bad_q      <= 1'b0;
            skip_q     <= 1'b0;
            refH_q     <= '0;
            refV_q     <= '0;
            stable_q   <= '0;
            toCnt_q    <= '0;
            hAct_q     <= '0;
            vAct_q     <= '0;
            locked_q   <= 1'b0;
            lockLost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pixCnt_q   <= pixCnt_d;
            lineCnt_q  <= lineCnt_d;
            lineLen_q  <= lineLen_d;
            bad_q      <= bad_d;
            skip_q     <= skip_d;
            refH_q     <= refH_d;
            refV_q     <= refV_d;
            stable_q   <= stable_d;
            toCnt_q    <= toCnt_d;
            hAct_q     <= hAct_d;
            vAct_q     <= vAct_d;
            locked_q   <= (state_d == LOCKED);
            lockLost_q <= loss;
        end
    end

    // Closed gate parks syncs at their inactive level and blanks DE/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voutVs_q   <= ~VS_POL;
            voutHs_q   <= ~HS_POL;
            voutDe_q   <= 1'b0;
            voutData_q <= '0;
        end else if (pass) begin
            voutVs_q   <= vin_vs;
            voutHs_q   <= vin_hs;
            voutDe_q   <= vin_de;
            voutData_q <= vin_data;
        end else begin
            voutVs_q   <= ~VS_POL;
            voutHs_q   <= ~HS_POL;
            voutDe_q   <= 1'b0;
            voutData_q <= '0;
        end
    end

`ifdef VIN_ALIGN_STAT_EN
    logic [15:0] frameCnt_q;
    logic [7:0]  errCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameCnt_q <= '0;
            errCnt_q   <= '0;
        end else begin
            if (fs && pass)                  frameCnt_q <= frameCnt_q + 16'd1;
            if (loss && (errCnt_q != 8'hFF)) errCnt_q   <= errCnt_q + 8'd1;
        end
    end

    assign frame_cnt = frameCnt_q;
    assign err_cnt   = errCnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

    assign vout_vs      = voutVs_q;
    assign vout_hs      = voutHs_q;
    assign vout_de      = voutDe_q;
    assign vout_data    = voutData_q;
    assign video_locked = locked_q;
    assign lock_lost    = lockLost_q;
    assign h_active     = hAct_q;
    assign v_active     = vAct_q;

endmodule
